// File: rtl/dual_fetch_queue.sv
// Dual-port instruction fetch unit with a circular fetch queue that feeds decode two at a time.
// Define DUAL_FETCH_PERF_EN to add the fetched/full/redirect performance counters.
module dual_fetch_queue #(
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr0,
    output logic [31:0] imem_addr1,
    input  logic [31:0] imem_rd0,
    input  logic [31:0] imem_rd1,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [1:0]  deq_num,
    output logic        out_valid0,
    output logic [31:0] out_instr0,
    output logic [31:0] out_pc0,
    output logic        out_valid1,
    output logic [31:0] out_instr1,
    output logic [31:0] out_pc1
`ifdef DUAL_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_full_cycles,
    output logic [31:0] perf_redirects
`endif
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned AW = $clog2(IMEM_WORDS);

    logic [AW-1:0] r_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [AW-1:0] r_qPc    [QDEPTH];
    logic [31:0]   r_qInstr [QDEPTH];

    logic [AW-1:0] w_pcPlus1;
    logic [PW-1:0] w_headPlus1;
    logic [PW-1:0] w_tailPlus1;
    logic [1:0]    w_deqReq;
    logic [1:0]    w_effDeq;
    logic [CW-1:0] w_free;
    logic [1:0]    w_enqNum;
    logic          w_unusedRedirect;

    assign w_pcPlus1   = r_pc + AW'(1);
    assign w_headPlus1 = r_head + PW'(1);
    assign w_tailPlus1 = r_tail + PW'(1);

    assign imem_addr0 = 32'(r_pc);
    assign imem_addr1 = 32'(w_pcPlus1);

    // Pop request is clamped to what is queued; fetch width is limited by free slots at cycle start
    assign w_deqReq = (deq_num == 2'd3) ? 2'd2 : deq_num;
    assign w_effDeq = (CW'(w_deqReq) > r_count) ? r_count[1:0] : w_deqReq;
    assign w_free   = CW'(QDEPTH) - r_count;
    assign w_enqNum = (w_free >= CW'(2)) ? 2'd2 : w_free[1:0];

    // Only the in-range low bits of the redirect target matter
    assign w_unusedRedirect = ^redirect_pc;

    assign out_valid0 = (r_count >= CW'(1));
    assign out_valid1 = (r_count >= CW'(2));
    assign out_pc0    = 32'(r_qPc[r_head]);
    assign out_instr0 = r_qInstr[r_head];
    assign out_pc1    = 32'(r_qPc[w_headPlus1]);
    assign out_instr1 = r_qInstr[w_headPlus1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= AW'(RESET_PC);
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc[AW-1:0];
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_pc    <= r_pc + AW'(w_enqNum);
            r_count <= r_count - CW'(w_effDeq) + CW'(w_enqNum);
            r_head  <= r_head + PW'(w_effDeq);
            r_tail  <= r_tail + PW'(w_enqNum);
        end
    end

    // Storage has no reset; validity is tracked entirely by count
    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            if (w_enqNum != 2'd0) begin
                r_qPc[r_tail]    <= r_pc;
                r_qInstr[r_tail] <= imem_rd0;
            end
            if (w_enqNum == 2'd2) begin
                r_qPc[w_tailPlus1]    <= w_pcPlus1;
                r_qInstr[w_tailPlus1] <= imem_rd1;
            end
        end
    end

`ifdef DUAL_FETCH_PERF_EN
    logic [31:0] r_perfFetched;
    logic [31:0] r_perfFullCycles;
    logic [31:0] r_perfRedirects;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perfFetched    <= '0;
            r_perfFullCycles <= '0;
            r_perfRedirects  <= '0;
        end else if (redirect_valid) begin
            r_perfRedirects <= r_perfRedirects + 32'd1;
        end else begin
            r_perfFetched <= r_perfFetched + 32'(w_enqNum);
            if (r_count == CW'(QDEPTH)) begin
                r_perfFullCycles <= r_perfFullCycles + 32'd1;
            end
        end
    end

    assign perf_fetched     = r_perfFetched;
    assign perf_full_cycles = r_perfFullCycles;
    assign perf_redirects   = r_perfRedirects;
`endif

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Scoreboard bench for dual_fetch_queue: a reference queue of {pc, instr} is filled on modelled fetches
// and compared against the two output slots every cycle.
module tb_dual_fetch_queue;

    localparam int unsigned QDEPTH     = 4;
    localparam int unsigned RESET_PC   = 0;
    localparam int unsigned IMEM_WORDS = 64;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr0;
    logic [31:0] imem_addr1;
    logic [31:0] imem_rd0;
    logic [31:0] imem_rd1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  deq_num;
    logic        out_valid0;
    logic [31:0] out_instr0;
    logic [31:0] out_pc0;
    logic        out_valid1;
    logic [31:0] out_instr1;
    logic [31:0] out_pc1;
`ifdef DUAL_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_full_cycles;
    logic [31:0] perf_redirects;
`endif

    int checks   = 0;
    int failures = 0;

    entry_t      expQ[$];
    int unsigned mPc;
    logic [31:0] mFetched;
    logic [31:0] mFull;
    logic [31:0] mRedir;

    dual_fetch_queue #(
        .QDEPTH    (QDEPTH),
        .RESET_PC  (RESET_PC),
        .IMEM_WORDS(IMEM_WORDS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr0    (imem_addr0),
        .imem_addr1    (imem_addr1),
        .imem_rd0      (imem_rd0),
        .imem_rd1      (imem_rd1),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .deq_num       (deq_num),
        .out_valid0    (out_valid0),
        .out_instr0    (out_instr0),
        .out_pc0       (out_pc0),
        .out_valid1    (out_valid1),
        .out_instr1    (out_instr1),
        .out_pc1       (out_pc1)
`ifdef DUAL_FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_full_cycles(perf_full_cycles),
        .perf_redirects  (perf_redirects)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word k holds 0x1000+k; reads are combinational
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h1000 + (addr % IMEM_WORDS);
    endfunction

    assign imem_rd0 = memWord(imem_addr0);
    assign imem_rd1 = memWord(imem_addr1);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkCycle();
        checkOutput("addr0", imem_addr0, 32'(mPc));
        checkOutput("addr1", imem_addr1, 32'((mPc + 1) % IMEM_WORDS));
        checkOutput("valid0", 32'(out_valid0), 32'(expQ.size() >= 1));
        checkOutput("valid1", 32'(out_valid1), 32'(expQ.size() >= 2));
        if (expQ.size() >= 1) begin
            checkOutput("pc0", out_pc0, expQ[0].pc);
            checkOutput("instr0", out_instr0, expQ[0].instr);
        end
        if (expQ.size() >= 2) begin
            checkOutput("pc1", out_pc1, expQ[1].pc);
            checkOutput("instr1", out_instr1, expQ[1].instr);
        end
`ifdef DUAL_FETCH_PERF_EN
        checkOutput("perfFetched", perf_fetched, mFetched);
        checkOutput("perfFull", perf_full_cycles, mFull);
        checkOutput("perfRedirects", perf_redirects, mRedir);
`endif
    endtask

    task automatic modelStep(input logic r, input logic rv, input logic [31:0] rp, input logic [1:0] dn);
        int cnt;
        int req;
        int eff;
        int enq;
        if (r) begin
            expQ.delete();
            mPc      = RESET_PC % IMEM_WORDS;
            mFetched = '0;
            mFull    = '0;
            mRedir   = '0;
        end else if (rv) begin
            expQ.delete();
            mPc    = rp % IMEM_WORDS;
            mRedir = mRedir + 32'd1;
        end else begin
            cnt = expQ.size();
            req = (dn == 2'd3) ? 2 : int'(dn);
            eff = (req < cnt) ? req : cnt;
            enq = ((QDEPTH - cnt) < 2) ? (QDEPTH - cnt) : 2;
            if (cnt == QDEPTH) mFull = mFull + 32'd1;
            for (int i = 0; i < eff; i++) void'(expQ.pop_front());
            for (int i = 0; i < enq; i++) begin
                entry_t e;
                e.pc    = 32'((mPc + i) % IMEM_WORDS);
                e.instr = memWord(e.pc);
                expQ.push_back(e);
            end
            mPc      = (mPc + enq) % IMEM_WORDS;
            mFetched = mFetched + 32'(enq);
        end
    endtask

    // Drive one cycle of inputs, check the current outputs, then advance the model across the edge
    task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rp, input logic [1:0] dn);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        deq_num        = dn;
        #1;
        checkCycle();
        modelStep(r, rv, rp, dn);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_num        = 2'd0;
        mFetched       = '0;
        mFull          = '0;
        mRedir         = '0;
        mPc            = 0;
        @(posedge clk);
        #1;
        modelStep(1'b1, 1'b0, 32'd0, 2'd0);

        // Fill from reset, then hold while full
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'd0, 2'd0);

        // Steady dual drain and refill
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'd0, 2'd2);

        // Single pops alternating with stalls
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'd0, (i % 2 == 0) ? 2'd1 : 2'd0);

        // Build count=3, then redirect near the top of memory with a same-cycle pop request
        applyStimulus(1'b0, 1'b1, 32'd0, 2'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd1);
        applyStimulus(1'b0, 1'b1, 32'h3E, 2'd2);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0, 2'd0);

        // Over-requested pops on an empty queue and deq_num=3
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FF05, 2'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd2);
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd3);
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd3);
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd0);

        // Random mix of pops and occasional redirects
        for (int i = 0; i < 60; i++) begin
            logic rv;
            rv = ($urandom_range(0, 9) == 0);
            applyStimulus(1'b0, rv, $urandom(), 2'($urandom_range(0, 3)));
        end

        // Fill completely, then reset together with a redirect and a pop request
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0, 2'd0);
        applyStimulus(1'b1, 1'b1, 32'h20, 2'd2);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_fetch_queue.md
Name: dual_fetch_queue

Overview:
- Instruction-fetch initiator for the dual-read-port, asynchronous-read, word-indexed instruction memory.
- Drives both memory address ports every cycle (PC and PC+1) and captures up to two instruction words per cycle into a small circular fetch queue.
- Presents the two oldest queued instructions to the decode stage, which pops 0, 1 or 2 per cycle.
- Supports a redirect (branch/jump) that flushes the queue and reloads the PC.

Parameters:
- QDEPTH, 4: fetch queue entries; power of two, at least 2.
- RESET_PC, 0: word index loaded into the PC on reset.
- IMEM_WORDS, 64: instruction memory size in words; all PC arithmetic is modulo this value; power of two.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr0  output  32  word index for memory read port 0; equals pc.
- imem_addr1  output  32  word index for memory read port 1; equals (pc+1) mod IMEM_WORDS.
- imem_rd0  input  32  word returned combinationally for imem_addr0.
- imem_rd1  input  32  word returned combinationally for imem_addr1.
- redirect_valid  input  1  flush the queue and load redirect_pc.
- redirect_pc  input  32  new word index; used modulo IMEM_WORDS.
- deq_num  input  2  number of entries decode pops this cycle; 0, 1 or 2.
- out_valid0  output  1  queue head is valid.
- out_instr0  output  32  instruction word at the queue head.
- out_pc0  output  32  word index of the queue head.
- out_valid1  output  1  second-oldest entry is valid.
- out_instr1  output  32  instruction word of the second-oldest entry.
- out_pc1  output  32  word index of the second-oldest entry.

Behaviour:
- State: pc, count (0..QDEPTH), head pointer, tail pointer, and queue storage of {pc, instr} per entry.
- Reset (rst=1 at an edge):
  - pc=RESET_PC mod IMEM_WORDS; count=0; head=tail=0.
  - out_valid0=out_valid1=0. Storage contents are don't-care.
  - Reset overrides redirect_valid and deq_num in the same cycle.
  - A reset asserted mid-operation discards all queued entries.
- Address outputs are combinational from pc. No memory handshake: data is valid in the same cycle it is addressed.
- Outputs come combinationally from registered queue state:
  - out_valid0 = (count>=1); out_valid1 = (count>=2).
  - Entry fields show the entries at head and head+1 (mod QDEPTH).
  - Invalid entries show don't-care data.
- Dequeue count per cycle:
  - eff_deq = min(deq_num, count).
  - deq_num=3 is treated as 2.
  - Popping more than count is clamped, not an error.
- Enqueue count per cycle:
  - enq_num = min(2, QDEPTH - count), computed from the count at the start of the cycle.
  - Slots freed by a same-cycle dequeue are not reused until the next cycle.
- On enqueue:
  - With enq_num>=1, entry tail gets {pc, imem_rd0}.
  - With enq_num=2, entry tail+1 gets {(pc+1) mod IMEM_WORDS, imem_rd1}.
- Per-edge update when redirect_valid=0:
  - head += eff_deq; tail += enq_num; both mod QDEPTH.
  - count = count - eff_deq + enq_num.
  - pc = (pc + enq_num) mod IMEM_WORDS.
- Queue full (count=QDEPTH): no fetch, pc holds; dequeue still allowed.
- Queue empty: outputs are invalid, and the fetch of pc and pc+1 proceeds normally.
- Wrap-around: pc=IMEM_WORDS-1 fetches entries with pc IMEM_WORDS-1 and 0, then advances to 1.
- Redirect (redirect_valid=1, rst=0):
  - count=0, head=tail=0, pc=redirect_pc mod IMEM_WORDS.
  - deq_num is ignored; nothing is enqueued that cycle.
  - The first instruction from the new PC is visible at out_valid0 one cycle after the redirect edge.
- Latency: an instruction addressed in cycle N is visible at the outputs in cycle N+1 at the earliest.

Optional Feature:
- Macro: DUAL_FETCH_PERF_EN.
- When defined, adds three outputs:
  - perf_fetched (32 bits): total words enqueued.
  - perf_full_cycles (32 bits): cycles with count=QDEPTH and no redirect.
  - perf_redirects (32 bits): redirect cycles.
- All three counters clear on rst and wrap at 2^32.
- When undefined, these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then deq_num=0 for 3 cycles, memory word k = 0x1000+k → cycle 1 enqueues pcs 0,1; cycle 2 enqueues 2,3; queue full (count 4) with pc=4 and held; out_instr0=0x1000, out_instr1=0x1001.
- Steady deq_num=2 from a full queue → exactly 2 words popped and 2 fetched per cycle after the first drain cycle; out_pc0 sequence 0,2,4,… with no gaps or duplicates.
- deq_num=1 alternating with 0 → each pc appears exactly once at out_pc0 in ascending order; count never exceeds 4.
- Redirect to pc=0x3E while count=3, deq_num=2 in the same cycle → next cycle out_valid0=0; following cycle out_pc0=0x3E, out_pc1=0x3F; then pcs 0 and 1 follow (wrap at 64).
- deq_num=2 with count=1 → clamped: count becomes 0 plus this cycle's enqueue; no underflow, head advances by 1.
- rst asserted together with redirect_valid=1 and count=4 → pc=RESET_PC, count=0, both out_valid low next cycle; with DUAL_FETCH_PERF_EN defined, all three perf counters read 0.
